sap_out_bcd_scanner: RTL and testbench

Converts the SAP-1 8-bit output-register value into three BCD digits with a sequential shift-add-3 (double-dabble) engine, then time-multiplexes those digits onto a single 4-bit BCD bus. It sits directly upstream of the BCD-to-seven-segment decoder: its `bcd` output feeds the decoder input, and its `an` output drives the common digit enables of a 3-digit display.

---
 rtl/sap_out_bcd_scanner.sv | 140 ++++++++++++++
 tb/tb_sap_out_bcd_scanner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sap_out_bcd_scanner.sv
// rtl/sap_out_bcd_scanner.sv - SAP-1 output value to 3-digit BCD with multiplexed digit scan
// Optional leading-zero blanking: define SAP_DISP_LZB_EN.
module sap_out_bcd_scanner #(
    parameter int REFRESH_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic       valid,
    output logic [3:0] bcd,
    output logic [2:0] an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t      state;
    logic [7:0]  shreg;
    logic [11:0] scratch;
    logic [11:0] adj;
    logic [2:0]  iter;
    logic [3:0]  hund;
    logic [3:0]  tens;
    logic [3:0]  ones;

    logic [CW-1:0] refresh;
    logic [1:0]    idx;
    logic [2:0]    onehot;
    logic [2:0]    en_mask;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            valid   <= 1'b0;
            shreg   <= 8'd0;
            scratch <= 12'd0;
            iter    <= 3'd0;
            hund    <= 4'd0;
            tens    <= 4'd0;
            ones    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg   <= data;
                        scratch <= 12'd0;
                        iter    <= 3'd0;
                        busy    <= 1'b1;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    // Adjust then shift {scratch, shreg} left by one in a single step.
                    scratch <= {adj[10:0], shreg[7]};
                    shreg   <= {shreg[6:0], 1'b0};
                    iter    <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    hund  <= scratch[11:8];
                    tens  <= scratch[7:4];
                    ones  <= scratch[3:0];
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Free-running scan, deliberately decoupled from the conversion FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh <= '0;
            idx     <= 2'd0;
        end else if (refresh == REF_MAX) begin
            refresh <= '0;
            idx     <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            refresh <= refresh + 1'b1;
        end
    end

    always_comb begin
        bcd    = 4'd0;
        onehot = 3'b000;
        case (idx)
            2'd0: begin
                bcd    = ones;
                onehot = 3'b001;
            end
            2'd1: begin
                bcd    = tens;
                onehot = 3'b010;
            end
            2'd2: begin
                bcd    = hund;
                onehot = 3'b100;
            end
            default: begin
                bcd    = 4'd0;
                onehot = 3'b000;
            end
        endcase
    end

`ifdef SAP_DISP_LZB_EN
    always_comb begin
        en_mask    = 3'b111;
        en_mask[2] = (hund != 4'd0);
        en_mask[1] = (hund != 4'd0) || (tens != 4'd0);
    end
`else
    assign en_mask = 3'b111;
`endif

    assign an = valid ? (onehot & en_mask) : 3'b000;

endmodule

// File: tb/tb_sap_out_bcd_scanner.sv
// tb/tb_sap_out_bcd_scanner.sv - scoreboard bench for sap_out_bcd_scanner
module tb_sap_out_bcd_scanner;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] data;
    logic       busy;
    logic       valid;
    logic [3:0] bcd;
    logic [2:0] an;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } dig_t;

    dig_t exp_q[$];

    // Reference scan position and currently displayed digits
    int         m_ref;
    int         m_idx;
    logic       m_valid;
    dig_t       m_dig;

    sap_out_bcd_scanner #(.REFRESH_DIV(RD)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .data (data),
        .busy (busy),
        .valid(valid),
        .bcd  (bcd),
        .an   (an)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ref <= 0;
            m_idx <= 0;
        end else if (m_ref == RD - 1) begin
            m_ref <= 0;
            m_idx <= (m_idx == 2) ? 0 : m_idx + 1;
        end else begin
            m_ref <= m_ref + 1;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_frame(input string tag);
        logic [2:0] ean;
        logic [3:0] ebcd;
        for (int i = 0; i < 3 * RD; i++) begin
            @(negedge clk);
            ebcd = (m_idx == 0) ? m_dig.o : (m_idx == 1) ? m_dig.t : m_dig.h;
            ean  = m_valid ? 3'(1 << m_idx) : 3'b000;
`ifdef SAP_DISP_LZB_EN
            if (m_dig.h == 4'd0) ean[2] = 1'b0;
            if (m_dig.h == 4'd0 && m_dig.t == 4'd0) ean[1] = 1'b0;
`endif
            chk({tag, "_an"}, {5'd0, an}, {5'd0, ean});
            chk({tag, "_bcd"}, {4'd0, bcd}, {4'd0, ebcd});
        end
    endtask

    task automatic convert(input logic [7:0] d, input int extra_at, input logic [7:0] extra_d);
        int cnt;
        dig_t e;
        @(negedge clk);
        load = 1'b1;
        data = d;
        exp_q.push_back('{h: 4'(d / 100), t: 4'((d / 10) % 10), o: 4'(d % 10)});
        @(negedge clk);
        load = 1'b0;
        cnt = 0;
        while (busy && cnt < 20) begin
            if (cnt == extra_at) begin
                load = 1'b1;
                data = extra_d;
            end else begin
                load = 1'b0;
            end
            cnt++;
            @(negedge clk);
        end
        load = 1'b0;
        chk("busy_cycles", 8'(cnt), 8'd9);
        chk("valid_after", {7'd0, valid}, 8'd1);
        chk("q_nonempty", {7'd0, exp_q.size() != 0}, 8'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            m_dig   = e;
            m_valid = 1'b1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        data    = 8'd0;
        m_valid = 1'b0;
        m_dig   = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_valid", {7'd0, valid}, 8'd0);
        chk("rst_an", {5'd0, an}, 8'd0);
        chk("rst_bcd", {4'd0, bcd}, 8'd0);
        rst = 1'b0;
        check_frame("blank");
        chk("blank_valid", {7'd0, valid}, 8'd0);
        chk("blank_busy", {7'd0, busy}, 8'd0);

        convert(8'd255, -1, 8'd0);
        check_frame("d255");
        convert(8'd0, -1, 8'd0);
        check_frame("d0");
        convert(8'd100, -1, 8'd0);
        check_frame("d100");
        convert(8'd9, -1, 8'd0);
        check_frame("d9");

        // Second load during busy must be dropped, not queued.
        convert(8'd128, 3, 8'd37);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_requeue_busy", {7'd0, busy}, 8'd0);
        end
        check_frame("d128");

        convert(8'd7, -1, 8'd0);
        check_frame("d7");
        convert(8'd42, -1, 8'd0);
        check_frame("d42");
        convert(8'd200, -1, 8'd0);
        check_frame("d200");

        // Abort a conversion with an asynchronous reset mid-CONVERT.
        @(negedge clk);
        load = 1'b1;
        data = 8'd99;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_pre", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_valid", {7'd0, valid}, 8'd0);
        chk("abort_an", {5'd0, an}, 8'd0);
        chk("abort_bcd", {4'd0, bcd}, 8'd0);
        m_valid = 1'b0;
        m_dig   = '0;
        @(negedge clk);
        rst = 1'b0;
        check_frame("post_rst");

        convert(8'd63, -1, 8'd0);
        check_frame("d63");
        chk("q_empty", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
